// File: rtl/lsp_prev_compose.sv
// ---------------------------------------------------------------------------
// lsp_prev_compose
//
// G.729 LSP predictor compose stage. On start, for j = 0..M-1:
//   lsp[j] = extract_h( L_mult(lsp_ele[j], fg_sum[j])
//                     + sum_k L_mult(freq_prev[k][j], fg[k][j]) )
// The operands are read from an internal 2048x32 scratch RAM and a 4096x32
// constant ROM, and each result is written back to scratch RAM.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   start / done         start is level-sampled in IDLE/DONE; done is high in DONE
//   lspele, freq_prev    scratch base addresses of lsp_ele[j] and freq_prev[k][j]
//   lsp                  scratch base address for the results
//   fg, fg_sum           ROM base addresses of fg[k][j] and fg_sum[j]
//   Mux0Sel..Mux3Sel     scratch read addr / write addr / write data / write
//                        enable source select: 0 = test port, 1 = FSM
//   testReadRequested, testWriteRequested, testWriteOut, testWrite
//                        test-port access to the scratch RAM
//   readIn               scratch RAM registered read data
//
// Build option
//   LSP_PREV_COMPOSE_SAT_EN : ITU basic-op saturation in L_mult/L_add
//                             (bit-exact G.729). When it is not defined the
//                             arithmetic wraps in 32-bit two's complement.
//
// ROM layout: fg mode m at 64*m + 10*k + j, fg_sum mode m at 128 + 16*m + j,
// all other words read as zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start after reset
// RD_ELE   | two cycles: address, then lsp_ele[j] and fg_sum[j] valid
// MULT     | acc = L_mult(lsp_ele[j], fg_sum[j])
// RD_PREV  | two cycles: address, then freq_prev[k][j] and fg[k][j] valid
// MAC      | acc = L_mac(acc, freq_prev[k][j], fg[k][j]); k++
// WRITE    | scratch[lsp+j] = sign-extended acc[31:16]; j++
// DONE     | done high; start begins a new frame
// ---------------------------------------------------------------------------
module lsp_prev_compose #(
  parameter int M     = 10,
  parameter int MA_NP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [10:0] lspele,
  input  logic [10:0] freq_prev,
  input  logic [10:0] lsp,
  input  logic [11:0] fg,
  input  logic [11:0] fg_sum,
  input  logic        Mux0Sel,
  input  logic        Mux1Sel,
  input  logic        Mux2Sel,
  input  logic        Mux3Sel,
  input  logic [10:0] testReadRequested,
  input  logic [10:0] testWriteRequested,
  input  logic [31:0] testWriteOut,
  input  logic        testWrite,
  output logic [31:0] readIn
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ELE,
    ST_MULT,
    ST_RD_PREV,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // fg[mode][k][j], mode-major then k-major
  localparam logic [15:0] FG_TAB [80] = '{
    16'd8421, 16'd9109, 16'd9175, 16'd8965, 16'd9034, 16'd9057, 16'd8765, 16'd8775, 16'd9106, 16'd8673,
    16'd7018, 16'd7189, 16'd7638, 16'd7307, 16'd7444, 16'd7379, 16'd7038, 16'd6956, 16'd6930, 16'd6868,
    16'd5472, 16'd4990, 16'd5134, 16'd5177, 16'd5246, 16'd5141, 16'd5206, 16'd5095, 16'd4830, 16'd5147,
    16'd4056, 16'd3031, 16'd2614, 16'd3024, 16'd2916, 16'd2713, 16'd3309, 16'd3237, 16'd2857, 16'd3473,
    16'd7733, 16'd7880, 16'd8188, 16'd8175, 16'd8247, 16'd8490, 16'd8637, 16'd8601, 16'd8359, 16'd7569,
    16'd4210, 16'd3031, 16'd2552, 16'd3473, 16'd3876, 16'd3853, 16'd4184, 16'd4154, 16'd3909, 16'd3968,
    16'd3214, 16'd1930, 16'd1313, 16'd2143, 16'd2493, 16'd2385, 16'd2755, 16'd2706, 16'd2542, 16'd2919,
    16'd3024, 16'd1592, 16'd940,  16'd1631, 16'd1723, 16'd1579, 16'd2034, 16'd2084, 16'd1913, 16'd2601
  };

  localparam logic [15:0] FG_SUM_TAB [20] = '{
    16'd7798,  16'd8447,  16'd8205,  16'd8293,  16'd8126,  16'd8477,  16'd8447,  16'd8703,  16'd9043,  16'd8604,
    16'd14585, 16'd18333, 16'd19772, 16'd17344, 16'd16426, 16'd16459, 16'd15155, 16'd15220, 16'd16043, 16'd15708
  };

  function automatic logic [15:0] rom_lookup(input logic [11:0] a);
    logic [15:0] v;
    v = '0;
    if (a < 12'd40)
      v = FG_TAB[a[6:0]];
    else if (a >= 12'd64 && a < 12'd104)
      v = FG_TAB[a[6:0] - 7'd24];
    else if (a >= 12'd128 && a < 12'd138)
      v = FG_SUM_TAB[a[4:0]];
    else if (a >= 12'd144 && a < 12'd154)
      v = FG_SUM_TAB[a[4:0] - 5'd6];
    return v;
  endfunction

  function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    logic [31:0]        r;
    p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    r = {p[30:0], 1'b0};
`ifdef LSP_PREV_COMPOSE_SAT_EN
    // only -32768 * -32768 reaches 0x40000000 before the doubling
    if (p == 32'sh4000_0000)
      r = 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  function automatic logic [31:0] l_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] s;
    s = x + y;
`ifdef LSP_PREV_COMPOSE_SAT_EN
    if ((x[31] == y[31]) && (s[31] != x[31]))
      s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s;
  endfunction

  state_t      state, state_n;
  logic        rd_ph, rd_ph_n;
  logic [3:0]  j, j_n;
  logic [2:0]  k, k_n;
  logic [31:0] acc, acc_n;
  logic        fsm_we;

  logic [6:0]  k_off;
  logic [10:0] fsm_rd_addr;
  logic [11:0] rom_addr;
  // the ROM word's upper half is only sign extension, so just [15:0] is kept
  logic [15:0] rom_q;

  logic [31:0] ram [2048];
  logic [31:0] ram_q;
  logic [10:0] ram_rd_addr;
  logic [10:0] ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic        ram_we;

  // The read address depends only on state/j/k, so it stays put through the
  // data-valid RD cycle and the following MULT/MAC; the registered outputs
  // therefore still hold the operands when they are consumed.
  always_comb begin
    k_off = 7'(k) * 7'(M);
    if (state == ST_RD_PREV || state == ST_MAC) begin
      fsm_rd_addr = freq_prev + 11'(k_off) + 11'(j);
      rom_addr    = fg + 12'(k_off) + 12'(j);
    end else begin
      fsm_rd_addr = lspele + 11'(j);
      rom_addr    = fg_sum + 12'(j);
    end
  end

  assign ram_rd_addr = Mux0Sel ? fsm_rd_addr : testReadRequested;
  assign ram_wr_addr = Mux1Sel ? (lsp + 11'(j)) : testWriteRequested;
  assign ram_wr_data = Mux2Sel ? {{16{acc[31]}}, acc[31:16]} : testWriteOut;
  assign ram_we      = Mux3Sel ? fsm_we : testWrite;

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[ram_wr_addr] <= ram_wr_data;
    ram_q <= ram[ram_rd_addr];
  end

  always_ff @(posedge clk) begin
    rom_q <= rom_lookup(rom_addr);
  end

  assign readIn = ram_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rd_ph <= 1'b0;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_n;
      rd_ph <= rd_ph_n;
      j     <= j_n;
      k     <= k_n;
    end
  end

  // MULT overwrites the accumulator, so it needs no reset
  always_ff @(posedge clk) begin
    acc <= acc_n;
  end

  always_comb begin
    state_n = state;
    rd_ph_n = 1'b0;
    j_n     = j;
    k_n     = k;
    acc_n   = acc;
    fsm_we  = 1'b0;
    done    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        j_n = '0;
        k_n = '0;
        if (start)
          state_n = ST_RD_ELE;
      end
      ST_RD_ELE: begin
        if (!rd_ph)
          rd_ph_n = 1'b1;
        else
          state_n = ST_MULT;
      end
      ST_MULT: begin
        acc_n   = l_mult(ram_q[15:0], rom_q);
        k_n     = '0;
        state_n = ST_RD_PREV;
      end
      ST_RD_PREV: begin
        if (!rd_ph)
          rd_ph_n = 1'b1;
        else
          state_n = ST_MAC;
      end
      ST_MAC: begin
        acc_n = l_add(acc, l_mult(ram_q[15:0], rom_q));
        if (k == 3'(MA_NP - 1)) begin
          k_n     = '0;
          state_n = ST_WRITE;
        end else begin
          k_n     = k + 3'd1;
          state_n = ST_RD_PREV;
        end
      end
      ST_WRITE: begin
        fsm_we = 1'b1;
        if (j == 4'(M - 1)) begin
          j_n     = '0;
          state_n = ST_DONE;
        end else begin
          j_n     = j + 4'd1;
          state_n = ST_RD_ELE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          j_n     = '0;
          k_n     = '0;
          state_n = ST_RD_ELE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsp_prev_compose.sv
module tb_lsp_prev_compose;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [10:0] lspele = 11'd64;
  logic [10:0] freq_prev = 11'd128;
  logic [10:0] lsp = 11'd448;
  logic [11:0] fg = 12'd0;
  logic [11:0] fg_sum = 12'd128;
  logic        Mux0Sel = 1'b0;
  logic        Mux1Sel = 1'b0;
  logic        Mux2Sel = 1'b0;
  logic        Mux3Sel = 1'b0;
  logic [10:0] testReadRequested = '0;
  logic [10:0] testWriteRequested = '0;
  logic [31:0] testWriteOut = '0;
  logic        testWrite = 1'b0;
  logic [31:0] readIn;

  int total = 0;
  int bad = 0;

  localparam logic [10:0] ELE_B  = 11'd64;
  localparam logic [10:0] PREV_B = 11'd128;
  localparam logic [10:0] LSP_B  = 11'd448;
  localparam logic [11:0] FG_M0  = 12'd0;
  localparam logic [11:0] FG_M1  = 12'd64;
  localparam logic [11:0] SUM_M0 = 12'd128;
  localparam logic [11:0] SUM_M1 = 12'd144;

  lsp_prev_compose dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .lspele(lspele), .freq_prev(freq_prev), .lsp(lsp), .fg(fg), .fg_sum(fg_sum),
    .Mux0Sel(Mux0Sel), .Mux1Sel(Mux1Sel), .Mux2Sel(Mux2Sel), .Mux3Sel(Mux3Sel),
    .testReadRequested(testReadRequested), .testWriteRequested(testWriteRequested),
    .testWriteOut(testWriteOut), .testWrite(testWrite), .readIn(readIn)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    Mux1Sel = 1'b0; Mux2Sel = 1'b0; Mux3Sel = 1'b0;
    testWriteRequested = a;
    testWriteOut = d;
    testWrite = 1'b1;
    @(posedge clk); #1;
    testWrite = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a, output logic [31:0] d);
    Mux0Sel = 1'b0;
    testReadRequested = a;
    @(posedge clk); #1;
    d = readIn;
  endtask

  task automatic clear_area();
    for (int i = 0; i < 10; i++) wr(ELE_B + 11'(i), 32'h0);
    for (int i = 0; i < 40; i++) wr(PREV_B + 11'(i), 32'h0);
    for (int i = 0; i < 11; i++) wr(LSP_B + 11'(i), 32'h0);
  endtask

  task automatic run_frame(input logic we_sel, output int cycles);
    Mux0Sel = 1'b1; Mux1Sel = 1'b1; Mux2Sel = 1'b1; Mux3Sel = we_sel;
    testWrite = 1'b0;
    start = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end while (!done && cycles < 400);
    Mux0Sel = 1'b0; Mux1Sel = 1'b0; Mux2Sel = 1'b0; Mux3Sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
    wr(LSP_B, 32'hDEAD_BEEF);
    Mux0Sel = 1'b1; Mux1Sel = 1'b1; Mux2Sel = 1'b1; Mux3Sel = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b want=0", done); end
    Mux1Sel = 1'b0; Mux2Sel = 1'b0; Mux3Sel = 1'b0;
    rd(LSP_B, d);
    total++;
    if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL idle_no_write got=%h want=deadbeef", d); end
  endtask

  task automatic test_test_port();
    logic [31:0] d;
    wr(11'd5, 32'h0000_1234);
    rd(11'd5, d);
    total++;
    if (d !== 32'h0000_1234) begin bad++; $display("FAIL port_addr5 got=%h want=00001234", d); end
    wr(11'd2047, 32'hFFFF_FFFF);
    wr(11'd0, 32'h8000_0001);
    rd(11'd2047, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL port_addr2047 got=%h want=ffffffff", d); end
    rd(11'd0, d);
    total++;
    if (d !== 32'h8000_0001) begin bad++; $display("FAIL port_addr0 got=%h want=80000001", d); end
  endtask

  task automatic test_single_element();
    logic [31:0] d;
    logic [31:0] exp_v [4];
    int idx [4];
    int cyc;
    clear_area();
    wr(ELE_B + 11'd0, 32'd8192);
    wr(ELE_B + 11'd9, 32'hFFFF_E000);
    wr(LSP_B + 11'd10, 32'h5A5A_5A5A);
    fg = FG_M0; fg_sum = SUM_M0;
    run_frame(1'b1, cyc);
    total++;
    if (cyc !== 161) begin bad++; $display("FAIL single_cycles got=%0d want=161", cyc); end
    // 8192*7798*2>>16 = 1949 ; -8192*8604*2>>16 = -2151
    idx[0] = 0;  exp_v[0] = 32'h0000_079D;
    idx[1] = 9;  exp_v[1] = 32'hFFFF_F799;
    idx[2] = 4;  exp_v[2] = 32'h0000_0000;
    idx[3] = 10; exp_v[3] = 32'h5A5A_5A5A;
    for (int i = 0; i < 4; i++) begin
      rd(LSP_B + 11'(idx[i]), d);
      total++;
      if (d !== exp_v[i]) begin
        bad++;
        $display("FAIL single_lsp%0d got=%h want=%h", idx[i], d, exp_v[i]);
      end
    end
  endtask

  task automatic test_write_lock();
    logic [31:0] d;
    int cyc;
    wr(LSP_B + 11'd0, 32'hCAFE_F00D);
    wr(LSP_B + 11'd9, 32'hCAFE_F00D);
    run_frame(1'b0, cyc);
    total++;
    if (cyc !== 161) begin bad++; $display("FAIL lock_cycles got=%0d want=161", cyc); end
    rd(LSP_B + 11'd0, d);
    total++;
    if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL lock_lsp0 got=%h want=cafef00d", d); end
    rd(LSP_B + 11'd9, d);
    total++;
    if (d !== 32'hCAFE_F00D) begin bad++; $display("FAIL lock_lsp9 got=%h want=cafef00d", d); end
  endtask

  task automatic test_mac_path();
    logic [31:0] d;
    logic [31:0] exp_v [5];
    int idx [5];
    int cyc;
    clear_area();
    wr(ELE_B + 11'd2, 32'd4096);
    for (int k = 0; k < 4; k++) begin
      wr(PREV_B + 11'(10 * k), 32'd8192);
      wr(PREV_B + 11'(10 * k + 2), 32'd8192);
    end
    wr(PREV_B + 11'd15, 32'hFFFF_C000);
    fg = FG_M1; fg_sum = SUM_M1;
    run_frame(1'b1, cyc);
    total++;
    if (cyc !== 161) begin bad++; $display("FAIL mac_cycles got=%0d want=161", cyc); end
    // j0: 18181/4 -> 4545 ; j2: 19772/8 + 12993/4 -> 5719 ; j5: -3853/2 -> -1927
    idx[0] = 0; exp_v[0] = 32'h0000_11C1;
    idx[1] = 2; exp_v[1] = 32'h0000_1657;
    idx[2] = 5; exp_v[2] = 32'hFFFF_F879;
    idx[3] = 1; exp_v[3] = 32'h0000_0000;
    idx[4] = 9; exp_v[4] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      rd(LSP_B + 11'(idx[i]), d);
      total++;
      if (d !== exp_v[i]) begin
        bad++;
        $display("FAIL mac_lsp%0d got=%h want=%h", idx[i], d, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic seen;
    int cyc;
    for (int i = 0; i < 10; i++) wr(LSP_B + 11'(i), 32'h0);
    wr(LSP_B + 11'd5, 32'hA5A5_A5A5);
    Mux0Sel = 1'b1; Mux1Sel = 1'b1; Mux2Sel = 1'b1; Mux3Sel = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", seen); end
    Mux0Sel = 1'b0; Mux1Sel = 1'b0; Mux2Sel = 1'b0; Mux3Sel = 1'b0;
    rd(LSP_B + 11'd0, d);
    total++;
    if (d !== 32'h0000_11C1) begin bad++; $display("FAIL abort_lsp0 got=%h want=000011c1", d); end
    rd(LSP_B + 11'd2, d);
    total++;
    if (d !== 32'h0000_1657) begin bad++; $display("FAIL abort_lsp2 got=%h want=00001657", d); end
    rd(LSP_B + 11'd5, d);
    total++;
    if (d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL abort_lsp5 got=%h want=a5a5a5a5", d); end
    run_frame(1'b1, cyc);
    total++;
    if (cyc !== 161) begin bad++; $display("FAIL abort_restart_cycles got=%0d want=161", cyc); end
    rd(LSP_B + 11'd5, d);
    total++;
    if (d !== 32'hFFFF_F879) begin bad++; $display("FAIL abort_restart_lsp5 got=%h want=fffff879", d); end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic [31:0] e2, e3;
    int cyc;
    clear_area();
    wr(ELE_B + 11'd2, 32'h0000_7FFF);
    wr(ELE_B + 11'd3, 32'hFFFF_8000);
    for (int k = 0; k < 4; k++) begin
      wr(PREV_B + 11'(10 * k + 2), 32'h0000_7FFF);
      wr(PREV_B + 11'(10 * k + 3), 32'hFFFF_8000);
    end
    fg = FG_M0; fg_sum = SUM_M1;
`ifdef LSP_PREV_COMPOSE_SAT_EN
    e2 = 32'h0000_7FFF;
    e3 = 32'hFFFF_8000;
`else
    // wrapped sums: 65534*44333 and -65536*41817
    e2 = 32'hFFFF_AD2B;
    e3 = 32'h0000_5CA7;
`endif
    run_frame(1'b1, cyc);
    total++;
    if (cyc !== 161) begin bad++; $display("FAIL sat_cycles got=%0d want=161", cyc); end
    rd(LSP_B + 11'd2, d);
    total++;
    if (d !== e2) begin bad++; $display("FAIL sat_pos got=%h want=%h", d, e2); end
    rd(LSP_B + 11'd3, d);
    total++;
    if (d !== e3) begin bad++; $display("FAIL sat_neg got=%h want=%h", d, e3); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] e2;
    int cyc;
`ifdef LSP_PREV_COMPOSE_SAT_EN
    e2 = 32'h0000_7FFF;
`else
    e2 = 32'hFFFF_AD2B;
`endif
    wr(LSP_B + 11'd2, 32'h0);
    Mux0Sel = 1'b1; Mux1Sel = 1'b1; Mux2Sel = 1'b1; Mux3Sel = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL b2b_done_clear got=%b want=0", done); end
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    Mux0Sel = 1'b0; Mux1Sel = 1'b0; Mux2Sel = 1'b0; Mux3Sel = 1'b0;
    total++;
    if (cyc !== 161) begin bad++; $display("FAIL b2b_cycles got=%0d want=161", cyc); end
    rd(LSP_B + 11'd2, d);
    total++;
    if (d !== e2) begin bad++; $display("FAIL b2b_lsp2 got=%h want=%h", d, e2); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_hold got=%b want=1", done); end
  endtask

  initial begin
    test_reset();
    test_test_port();
    test_single_element();
    test_write_lock();
    test_mac_path();
    test_reset_abort();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
